sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 40 ++++
 rtl/sram_arbiter_if.sv | 46 ++++
 rtl/sram_arbiter.sv | 165 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the codec SRAM arbiter.
//   ADDR_W / DATA_W : SRAM word address and data widths
//   CNT_W           : width of the access-stretch counter (WAIT_CYC up to 7)
//   state_t         : arbiter FSM states
//   served_t        : round-robin memory of the last port granted
//   strobe_t        : packed active-low SRAM strobe bundle plus its fixed encodings
package sram_arbiter_pkg;

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        RD_SETUP,
        RD_WAIT,
        WR_SETUP,
        WR_PULSE
    } state_t;

    typedef enum logic {
        SRV_PLAY = 1'b0,
        SRV_REC  = 1'b1
    } served_t;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic lb_n;
        logic ub_n;
    } strobe_t;

    // Both byte lanes are always enabled: every access is a full 16-bit word.
    localparam strobe_t STB_OFF    = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, lb_n: 1'b1, ub_n: 1'b1};
    localparam strobe_t STB_READ   = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1, lb_n: 1'b0, ub_n: 1'b0};
    localparam strobe_t STB_WSETUP = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1, lb_n: 1'b0, ub_n: 1'b0};
    localparam strobe_t STB_WPULSE = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0, lb_n: 1'b0, ub_n: 1'b0};

endpackage

// File: rtl/sram_arbiter_if.sv
// Bus bundle between the playback/record clients, the arbiter and the external SRAM.
//   play_req/play_addr -> play_data/play_ack   : playback read port
//   rec_req/rec_addr/rec_data -> rec_ack       : record write port
//   sram_addr, sram_dq_o, sram_dq_oe, strobes  : SRAM pins driven by the arbiter
//   sram_dq_i                                  : SRAM read data back to the arbiter
// Modports:
//   slave  : the arbiter's view (requests and SRAM read data in, everything else out)
//   master : the surrounding system's view (clients and SRAM model)
interface sram_arbiter_if;
    import sram_arbiter_pkg::*;

    logic              play_req;
    logic [ADDR_W-1:0] play_addr;
    logic [DATA_W-1:0] play_data;
    logic              play_ack;

    logic              rec_req;
    logic [ADDR_W-1:0] rec_addr;
    logic [DATA_W-1:0] rec_data;
    logic              rec_ack;

    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dq_o;
    logic              sram_dq_oe;
    logic [DATA_W-1:0] sram_dq_i;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic              sram_lb_n;
    logic              sram_ub_n;

    modport slave (
        input  play_req, play_addr, rec_req, rec_addr, rec_data, sram_dq_i,
        output play_data, play_ack, rec_ack,
        output sram_addr, sram_dq_o, sram_dq_oe,
        output sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n
    );

    modport master (
        output play_req, play_addr, rec_req, rec_addr, rec_data, sram_dq_i,
        input  play_data, play_ack, rec_ack,
        input  sram_addr, sram_dq_o, sram_dq_oe,
        input  sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n
    );

endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter sharing one asynchronous 16-bit SRAM between an audio playback
// reader and a record writer, clocked by the codec bit clock.
// Ports:
//   bclk   : bit clock, all flops on its rising edge
//   rst_n  : synchronous active-low reset; drops any in-flight access without an ack
//   bus    : sram_arbiter_if.slave -- client handshakes and registered SRAM pins
// Parameter:
//   WAIT_CYC (0..7) : extra SRAM cycles before read capture / write release
// Build option:
//   PLAY_PRIO_EN : when defined, play always wins over rec (DAC underrun protection);
//                  otherwise simultaneous requests alternate round-robin.
// Each access takes WAIT_CYC+3 cycles from the request being sampled in IDLE to its
// one-cycle ack, which is issued in the IDLE cycle following the access.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_CYC = 1
) (
    input logic           bclk,
    input logic           rst_n,
    sram_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYC);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    served_t           last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dq_o_q, dq_o_d;
    logic              dq_oe_q, dq_oe_d;
    strobe_t           stb_q, stb_d;
    logic [DATA_W-1:0] play_data_q, play_data_d;
    logic              play_ack_q, play_ack_d;
    logic              rec_ack_q, rec_ack_d;

    logic play_vld, rec_vld, grant_play, grant_rec;

    // A requester still holds req during its ack cycle, so that stale req is masked.
    always_comb begin
        play_vld = bus.play_req & ~play_ack_q;
`ifdef PLAY_PRIO_EN
        // Rec waits whenever play is asserting at all, including play's ack cycle,
        // so a continuously requesting player is never interleaved with writes.
        rec_vld    = bus.rec_req & ~rec_ack_q & ~bus.play_req;
        grant_play = play_vld;
`else
        rec_vld    = bus.rec_req & ~rec_ack_q;
        grant_play = play_vld & (~rec_vld | (last_q == SRV_REC));
`endif
        grant_rec  = rec_vld & ~grant_play;
    end

    always_ff @(posedge bclk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= SRV_REC;
            addr_q      <= '0;
            dq_o_q      <= '0;
            dq_oe_q     <= 1'b0;
            stb_q       <= STB_OFF;
            play_data_q <= '0;
            play_ack_q  <= 1'b0;
            rec_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
            stb_q       <= stb_d;
            play_data_q <= play_data_d;
            play_ack_q  <= play_ack_d;
            rec_ack_q   <= rec_ack_d;
        end
    end

    // All SRAM pins are registered: each branch sets the values seen in the next state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        addr_d      = addr_q;
        dq_o_d      = dq_o_q;
        dq_oe_d     = 1'b0;
        stb_d       = STB_OFF;
        play_data_d = play_data_q;
        play_ack_d  = 1'b0;
        rec_ack_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_play) begin
                    state_d = RD_SETUP;
                    addr_d  = bus.play_addr;
                    stb_d   = STB_READ;
                    last_d  = SRV_PLAY;
                end else if (grant_rec) begin
                    state_d = WR_SETUP;
                    addr_d  = bus.rec_addr;
                    dq_o_d  = bus.rec_data;
                    dq_oe_d = 1'b1;
                    stb_d   = STB_WSETUP;
                    last_d  = SRV_REC;
                end
            end

            RD_SETUP: begin
                state_d = RD_WAIT;
                cnt_d   = '0;
                stb_d   = STB_READ;
            end

            RD_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d     = IDLE;
                    play_data_d = bus.sram_dq_i;
                    play_ack_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    stb_d = STB_READ;
                end
            end

            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = '0;
                dq_oe_d = 1'b1;
                stb_d   = STB_WPULSE;
            end

            WR_PULSE: begin
                // Data keeps driving one cycle past we_n rising for SRAM hold time;
                // oe_n stays high throughout, so the next read cannot collide with it.
                dq_oe_d = 1'b1;
                if (cnt_q == WAIT_LAST) begin
                    state_d   = IDLE;
                    rec_ack_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    stb_d = STB_WPULSE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.play_data  = play_data_q;
    assign bus.play_ack   = play_ack_q;
    assign bus.rec_ack    = rec_ack_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_dq_o  = dq_o_q;
    assign bus.sram_dq_oe = dq_oe_q;
    assign bus.sram_ce_n  = stb_q.ce_n;
    assign bus.sram_oe_n  = stb_q.oe_n;
    assign bus.sram_we_n  = stb_q.we_n;
    assign bus.sram_lb_n  = stb_q.lb_n;
    assign bus.sram_ub_n  = stb_q.ub_n;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with a behavioural SRAM, a table of
// read/write vectors, hand-written corner sequences and concurrent random clients.
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    localparam int unsigned WAIT = 1;
    localparam int          LAT  = WAIT + 3;

    typedef struct {
        bit          wr;
        logic [17:0] addr;
        logic [15:0] data;
        logic [15:0] exp_data;
    } vec_t;

    typedef struct packed {
        logic [17:0] a;
        logic [15:0] d;
    } wr_t;

    logic bclk = 1'b0;
    logic rst_n = 1'b0;
    always #5 bclk = ~bclk;

    sram_arbiter_if bus();

    sram_arbiter #(.WAIT_CYC(WAIT)) dut (
        .bclk (bclk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int play_acks = 0;
    int rec_acks = 0;
    int contention = 0;
    int n_play = 0;
    int n_rec = 0;

    logic [15:0] rd_sb[$];
    wr_t         wr_sb[$];

    logic [4:0] strb;
    assign strb = {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_lb_n, bus.sram_ub_n};

    function automatic logic [15:0] pat(input logic [17:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    // Behavioural asynchronous SRAM: combinational read, write on clock edges with we_n low.
    logic [15:0] mem [0:(1<<ADDR_W)-1];
    assign bus.sram_dq_i = (!bus.sram_ce_n && !bus.sram_oe_n) ? mem[bus.sram_addr] : 16'h0000;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = pat(18'(i));
        mem[18'h00010] = 16'hBEEF;
        forever begin
            @(posedge bclk);
            if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_dq_oe)
                mem[bus.sram_addr] <= bus.sram_dq_o;
        end
    end

    always @(negedge bclk) begin
        if (bus.play_ack) play_acks++;
        if (bus.rec_ack) rec_acks++;
        if (bus.sram_dq_oe && !bus.sram_oe_n) contention++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Raise one request, wait (bounded) for its ack, drop the request in the ack cycle.
    task automatic xact(input bit wr, input logic [17:0] a, input logic [15:0] d,
                        output int lat, output int we_low, output bit got);
        if (wr) begin
            bus.rec_addr = a;
            bus.rec_data = d;
            bus.rec_req  = 1'b1;
        end else begin
            bus.play_addr = a;
            bus.play_req  = 1'b1;
        end
        lat    = 0;
        we_low = 0;
        got    = 1'b0;
        while (!got && lat < 64) begin
            @(negedge bclk);
            lat++;
            if (!bus.sram_we_n) we_low++;
            if (wr ? bus.rec_ack : bus.play_ack) got = 1'b1;
        end
        if (wr) bus.rec_req = 1'b0;
        else bus.play_req = 1'b0;
    endtask

    task automatic play_client(input int n);
        logic [17:0] a;
        logic [15:0] e;
        int l, w;
        bit g;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge bclk);
            a = 18'h20000 | 18'($urandom_range(0, 255));
            rd_sb.push_back(pat(a));
            n_play++;
            xact(1'b0, a, 16'h0000, l, w, g);
            e = rd_sb.pop_front();
            check("rand_play_ack", 32'(g), 1);
            if (g) check("rand_play_data", 32'(bus.play_data), 32'(e));
        end
    endtask

    task automatic rec_client(input int n);
        logic [17:0] a;
        logic [15:0] d;
        wr_t e;
        int l, w;
        bit g;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge bclk);
            a = 18'h10000 | 18'($urandom_range(0, 255));
            d = 16'($urandom);
            wr_sb.push_back('{a: a, d: d});
            n_rec++;
            xact(1'b1, a, d, l, w, g);
            e = wr_sb.pop_front();
            check("rand_rec_ack", 32'(g), 1);
            if (g) check("rand_rec_mem", 32'(mem[e.a]), 32'(e.d));
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vt[10];
    int   lat, we_low, ng, acks, pa0, ra0;
    bit   got;
    logic [15:0] e_rd;
    wr_t  e_wr;
    int   order[4];
    int   exp_order[4];

    initial begin
        vt[0] = '{1'b1, 18'h00000, 16'hFFFF, 16'h0000};
        vt[1] = '{1'b0, 18'h00000, 16'h0000, 16'hFFFF};
        vt[2] = '{1'b1, 18'h2AAAA, 16'h5555, 16'h0000};
        vt[3] = '{1'b0, 18'h2AAAA, 16'h0000, 16'h5555};
        vt[4] = '{1'b0, 18'h15555, 16'h0000, 16'hF0F0};
        vt[5] = '{1'b0, 18'h3FFFF, 16'h0000, 16'h1234};
        vt[6] = '{1'b1, 18'h15555, 16'h0F0F, 16'h0000};
        vt[7] = '{1'b0, 18'h15555, 16'h0000, 16'h0F0F};
        vt[8] = '{1'b0, 18'h00001, 16'h0000, 16'hA5A4};
        vt[9] = '{1'b0, 18'h00010, 16'h0000, 16'hBEEF};
`ifdef PLAY_PRIO_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif

        bus.play_req  = 1'b0;
        bus.play_addr = '0;
        bus.rec_req   = 1'b0;
        bus.rec_addr  = '0;
        bus.rec_data  = '0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge bclk);
        check("rst_strobes", 32'(strb), 'b11111);
        check("rst_dq_oe", 32'(bus.sram_dq_oe), 0);
        check("rst_addr", 32'(bus.sram_addr), 0);
        check("rst_dq_o", 32'(bus.sram_dq_o), 0);
        check("rst_play_data", 32'(bus.play_data), 0);
        check("rst_play_ack", 32'(bus.play_ack), 0);
        check("rst_rec_ack", 32'(bus.rec_ack), 0);
        rst_n = 1'b1;

        // First read after reset; req is held through the ack cycle to exercise masking.
        @(negedge bclk);
        bus.play_addr = 18'h00010;
        bus.play_req  = 1'b1;
        @(negedge bclk);
        check("rd_setup_addr", 32'(bus.sram_addr), 'h00010);
        check("rd_setup_strb", 32'(strb), 'b00100);
        check("rd_setup_dq_oe", 32'(bus.sram_dq_oe), 0);
        @(negedge bclk);
        check("rd_c2_no_ack", 32'(bus.play_ack), 0);
        @(negedge bclk);
        check("rd_c3_no_ack", 32'(bus.play_ack), 0);
        @(negedge bclk);
        check("rd_c4_ack", 32'(bus.play_ack), 1);
        check("rd_c4_data", 32'(bus.play_data), 'hBEEF);
        check("rd_c4_strb", 32'(strb), 'b11111);
        @(negedge bclk);
        bus.play_req = 1'b0;
        check("rd_mask_no_restart", 32'(bus.sram_ce_n), 1);
        acks = 0;
        repeat (6) begin
            @(negedge bclk);
            if (bus.play_ack) acks++;
        end
        check("rd_mask_single_ack", 32'(acks), 0);
        check("rd_data_held", 32'(bus.play_data), 'hBEEF);

        // Write at the top of the address space.
        bus.rec_addr = 18'h3FFFF;
        bus.rec_data = 16'h1234;
        bus.rec_req  = 1'b1;
        @(negedge bclk);
        check("wr_setup_addr", 32'(bus.sram_addr), 'h3FFFF);
        check("wr_setup_dq_o", 32'(bus.sram_dq_o), 'h1234);
        check("wr_setup_dq_oe", 32'(bus.sram_dq_oe), 1);
        check("wr_setup_strb", 32'(strb), 'b01100);
        we_low = 0;
        repeat (2) begin
            @(negedge bclk);
            if (!bus.sram_we_n) we_low++;
        end
        check("wr_we_low_cycles", 32'(we_low), 2);
        @(negedge bclk);
        check("wr_c4_ack", 32'(bus.rec_ack), 1);
        check("wr_c4_we_n", 32'(bus.sram_we_n), 1);
        check("wr_c4_dq_oe_hold", 32'(bus.sram_dq_oe), 1);
        bus.rec_req = 1'b0;
        @(negedge bclk);
        check("wr_c5_dq_oe", 32'(bus.sram_dq_oe), 0);
        check("wr_c5_no_ack", 32'(bus.rec_ack), 0);
        check("wr_mem", 32'(mem[18'h3FFFF]), 'h1234);

        // Table of single transactions, each checked through the scoreboard.
        for (int i = 0; i < 10; i++) begin
            if (vt[i].wr) wr_sb.push_back('{a: vt[i].addr, d: vt[i].data});
            else rd_sb.push_back(vt[i].exp_data);
            xact(vt[i].wr, vt[i].addr, vt[i].data, lat, we_low, got);
            check($sformatf("vec%0d_ack", i), 32'(got), 1);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
            if (vt[i].wr) begin
                e_wr = wr_sb.pop_front();
                check($sformatf("vec%0d_we_low", i), 32'(we_low), WAIT + 1);
                check($sformatf("vec%0d_mem", i), 32'(mem[e_wr.a]), 32'(e_wr.d));
            end else begin
                e_rd = rd_sb.pop_front();
                check($sformatf("vec%0d_data", i), 32'(bus.play_data), 32'(e_rd));
            end
            @(negedge bclk);
        end

        // Both requests held continuously from reset: grant order.
        rst_n = 1'b0;
        repeat (2) @(negedge bclk);
        rst_n = 1'b1;
        bus.play_addr = 18'h20001;
        bus.rec_addr  = 18'h10001;
        bus.rec_data  = 16'h7777;
        bus.play_req  = 1'b1;
        bus.rec_req   = 1'b1;
        order = '{-1, -1, -1, -1};
        ng = 0;
        for (int c = 0; c < 80 && ng < 4; c++) begin
            @(negedge bclk);
            if (bus.play_ack && ng < 4) begin
                order[ng] = 0;
                ng++;
            end
            if (bus.rec_ack && ng < 4) begin
                order[ng] = 1;
                ng++;
            end
        end
        bus.play_req = 1'b0;
        bus.rec_req  = 1'b0;
        check("rr_grants", 32'(ng), 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("rr_order%0d", k), 32'(order[k]), 32'(exp_order[k]));
        repeat (4) @(negedge bclk);

        // Reset in the middle of a read: access dropped, no ack.
        bus.play_addr = 18'h20005;
        bus.play_req  = 1'b1;
        @(negedge bclk);
        @(negedge bclk);
        check("rst_mid_in_wait", 32'(bus.sram_ce_n), 0);
        rst_n = 1'b0;
        bus.play_req = 1'b0;
        @(negedge bclk);
        check("rst_mid_strb", 32'(strb), 'b11111);
        check("rst_mid_dq_oe", 32'(bus.sram_dq_oe), 0);
        check("rst_mid_ack", 32'(bus.play_ack), 0);
        check("rst_mid_addr", 32'(bus.sram_addr), 0);
        check("rst_mid_play_data", 32'(bus.play_data), 0);
        rst_n = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge bclk);
            if (bus.play_ack) acks++;
        end
        check("rst_mid_no_late_ack", 32'(acks), 0);

        // Concurrent random clients.
        pa0 = play_acks;
        ra0 = rec_acks;
        fork
            play_client(1200);
            rec_client(1200);
        join
        repeat (4) @(negedge bclk);
        check("rand_play_ack_count", 32'(play_acks - pa0), 32'(n_play));
        check("rand_rec_ack_count", 32'(rec_acks - ra0), 32'(n_rec));
        check("no_bus_contention", 32'(contention), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
